// File: rtl/uart_rx.sv
// uart_rx - oversampling asynchronous serial receiver.
//
// Receives frames of: start bit (0), DATA_WIDTH data bits LSB first, an
// optional parity bit, and one stop bit (1). Each bit lasts i_prescale
// clocks. Each bit is sampled three times around its centre and the
// value is the 2-of-3 majority of those samples. The line rate and the
// parity settings are captured when the start bit is seen, and they are
// held for the rest of the frame.
//
// Ports
//   i_clk            clock, rising edge
//   i_rst            asynchronous reset, active low
//   i_rx_in          serial line, idle high, already synchronised
//   i_prescale       clocks per bit (8, 16 or 32)
//   i_parity_enable  1 = parity bit present between data and stop
//   i_parity_type    0 = even, 1 = odd
//   o_data           last word received without error
//   o_data_valid     one-cycle pulse when o_data is updated
//   o_parity_error   one-cycle pulse, parity mismatch on completed frame
//   o_stop_error     one-cycle pulse, stop bit sampled low
//   o_busy           high while a frame is in progress
//
// DATA_WIDTH must be at least 2.
module uart_rx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_rx_in,
  input  logic [5:0]            i_prescale,
  input  logic                  i_parity_enable,
  input  logic                  i_parity_type,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_data_valid,
  output logic                  o_parity_error,
  output logic                  o_stop_error,
  output logic                  o_busy
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // 2-of-3 majority vote of the three mid-bit samples.
  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

  // Expected parity bit. For even parity it is the XOR of the data bits.
  // For odd parity it is the inverse of that XOR.
  function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  state_t                state, state_nx;
  logic [5:0]            edge_cnt, edge_nx;
  logic [BW-1:0]         bit_cnt, bit_nx;
  logic [DATA_WIDTH-1:0] shift, shift_nx;
  logic [2:0]            samples, samples_nx;
  logic                  par_err, par_err_nx;
  logic [5:0]            prescale_q, prescale_nx;
  logic                  par_en_q, par_en_nx;
  logic                  par_odd_q, par_odd_nx;
  logic [DATA_WIDTH-1:0] data_nx;
  logic                  valid_nx, perr_nx, serr_nx;

  logic [5:0] half;
  logic       bit_end;
  logic       bit_val;

  assign half    = {1'b0, prescale_q[5:1]};
  // When prescale is 0, this compare wraps to 63. The bit period is then
  // long, but it still ends. So an illegal ratio can never hold the FSM.
  assign bit_end = (edge_cnt == (prescale_q - 6'd1));
  assign bit_val = majority3(samples);

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_nx    = state;
    edge_nx     = edge_cnt;
    bit_nx      = bit_cnt;
    shift_nx    = shift;
    samples_nx  = samples;
    par_err_nx  = par_err;
    prescale_nx = prescale_q;
    par_en_nx   = par_en_q;
    par_odd_nx  = par_odd_q;
    data_nx     = o_data;
    valid_nx    = 1'b0;
    perr_nx     = 1'b0;
    serr_nx     = 1'b0;

    // The edge counter and the mid-bit sampling are the same for every bit.
    if (state != IDLE) begin
      if (edge_cnt == (half - 6'd1)) begin
        samples_nx[0] = i_rx_in;
      end else if (edge_cnt == half) begin
        samples_nx[1] = i_rx_in;
      end else if (edge_cnt == (half + 6'd1)) begin
        samples_nx[2] = i_rx_in;
      end else begin
        samples_nx = samples;
      end
      if (bit_end) begin
        edge_nx = 6'd0;
      end else begin
        edge_nx = edge_cnt + 6'd1;
      end
    end else begin
      edge_nx = 6'd0;
    end

    case (state)
      IDLE: begin
        if (!i_rx_in) begin
          state_nx    = START;
          bit_nx      = '0;
          par_err_nx  = 1'b0;
          prescale_nx = i_prescale;
          par_en_nx   = i_parity_enable;
          par_odd_nx  = i_parity_type;
        end else begin
          state_nx = IDLE;
        end
      end
      START: begin
        if (bit_end) begin
          // A start bit that votes high was a glitch, so drop it quietly.
          state_nx = bit_val ? IDLE : DATA;
          bit_nx   = '0;
        end else begin
          state_nx = START;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_nx = {bit_val, shift[DATA_WIDTH-1:1]};
          if (bit_cnt == LAST_BIT) begin
            state_nx = par_en_q ? PARITY : STOP;
            bit_nx   = '0;
          end else begin
            bit_nx = bit_cnt + {{(BW-1){1'b0}}, 1'b1};
          end
        end else begin
          state_nx = DATA;
        end
      end
      PARITY: begin
        if (bit_end) begin
          par_err_nx = (bit_val != parity_bit(shift, par_odd_q));
          state_nx   = STOP;
        end else begin
          state_nx = PARITY;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_nx = IDLE;
          if (par_err || !bit_val) begin
            perr_nx = par_err;
            serr_nx = !bit_val;
          end else begin
            data_nx  = shift;
            valid_nx = 1'b1;
          end
        end else begin
          state_nx = STOP;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state          <= IDLE;
      edge_cnt       <= 6'd0;
      bit_cnt        <= '0;
      shift          <= '0;
      samples        <= 3'b000;
      par_err        <= 1'b0;
      prescale_q     <= 6'd0;
      par_en_q       <= 1'b0;
      par_odd_q      <= 1'b0;
      o_data         <= '0;
      o_data_valid   <= 1'b0;
      o_parity_error <= 1'b0;
      o_stop_error   <= 1'b0;
      o_busy         <= 1'b0;
    end else begin
      state          <= state_nx;
      edge_cnt       <= edge_nx;
      bit_cnt        <= bit_nx;
      shift          <= shift_nx;
      samples        <= samples_nx;
      par_err        <= par_err_nx;
      prescale_q     <= prescale_nx;
      par_en_q       <= par_en_nx;
      par_odd_q      <= par_odd_nx;
      o_data         <= data_nx;
      o_data_valid   <= valid_nx;
      o_parity_error <= perr_nx;
      o_stop_error   <= serr_nx;
      o_busy         <= (state_nx != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx - randomized self-checking bench for uart_rx.
// A frame-level model predicts, for each frame, the completion cycle, the
// received word and the error flags. It works them out from the oversampled
// line values and from where the three centre samples fall. A monitor
// checks o_data, o_busy and every pulse on each cycle. Directed frames
// also have literal expectations.
module tb_uart_rx;

  localparam int DW = 8;

  logic          clk;
  logic          rst_n;
  logic          rx;
  logic [5:0]    prescale;
  logic          par_en;
  logic          par_type;
  logic [DW-1:0] data;
  logic          data_valid;
  logic          perr;
  logic          serr;
  logic          busy;

  uart_rx #(.DATA_WIDTH(DW)) dut (
    .i_clk(clk), .i_rst(rst_n), .i_rx_in(rx), .i_prescale(prescale),
    .i_parity_enable(par_en), .i_parity_type(par_type),
    .o_data(data), .o_data_valid(data_valid), .o_parity_error(perr),
    .o_stop_error(serr), .o_busy(busy)
  );

  typedef struct { int t; logic [DW-1:0] d; bit ok; bit pe; bit se; } ev_t;
  typedef struct { int lo; int hi; } iv_t;

  ev_t           eq[$];
  iv_t           bq[$];
  int            cyc = 0;
  int            n_chk = 0;
  int            n_fail = 0;
  int            n_valid = 0;
  int            n_perr = 0;
  int            n_serr = 0;
  int            prev_end = 0;
  int            prev_lag = 0;
  bit            chk_en = 1'b0;
  logic [DW-1:0] mdl_data = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every cycle, compare the outputs with the frame model.
  always @(negedge clk) begin
    ev_t e;
    if (chk_en) begin
      while (bq.size() > 0 && bq[0].hi <= cyc) void'(bq.pop_front());
      chk("busy", busy, (bq.size() > 0 && bq[0].lo <= cyc) ? 32'd1 : 32'd0);
      if (data_valid || perr || serr) begin
        n_valid += data_valid ? 1 : 0;
        n_perr  += perr ? 1 : 0;
        n_serr  += serr ? 1 : 0;
        if (eq.size() == 0) begin
          chk("unexpected_pulse", {data_valid, perr, serr}, 32'd0);
        end else begin
          e = eq.pop_front();
          chk("pulse_time", cyc, e.t);
          chk("valid", data_valid, e.ok);
          chk("parity_err", perr, e.pe);
          chk("stop_err", serr, e.se);
          if (e.ok) mdl_data = e.d;
        end
      end else if (eq.size() > 0 && cyc > eq[0].t) begin
        e = eq.pop_front();
        chk("missing_pulse", 32'd0, 32'd1);
      end
      chk("data", data, mdl_data);
    end
  end

  task automatic drive(input logic v);
    @(negedge clk);
    rx = v;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1);
  endtask

  task automatic mid_reset();
    chk_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_data", data, 32'd0);
    chk("rst_valid", data_valid, 32'd0);
    chk("rst_perr", perr, 32'd0);
    chk("rst_serr", serr, 32'd0);
    chk("rst_busy", busy, 32'd0);
    eq.delete();
    bq.delete();
    mdl_data = '0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    prev_end = cyc + 1;
    prev_lag = 0;
    chk_en = 1'b1;
  endtask

  // Drive one frame and record what the receiver must report for it.
  task automatic send_frame(input logic [DW-1:0] d, input int p, input bit pen, input bit ptype,
                            input bit bad_par, input bit bad_stop, input bit flips,
                            input int gap, input int abort_idx);
    int nb, total, half, first_low, det, lag, b;
    logic bits [0:10];
    logic os [0:351];
    logic rec [0:10];
    logic [DW-1:0] rd;
    bit pe, se;
    ev_t e;
    iv_t iv;
    nb = 2 + DW + (pen ? 1 : 0);
    total = nb * p;
    half = p / 2;
    bits[0] = 1'b0;
    for (int i = 0; i < DW; i++) bits[1 + i] = d[i];
    if (pen) bits[1 + DW] = (^d) ^ ptype ^ bad_par;
    bits[nb - 1] = !bad_stop;
    idle(gap);
    for (int idx = 0; idx < total; idx++) begin
      @(negedge clk);
      if (idx == 0) begin
        first_low = cyc + 1;
        det = (first_low > prev_end) ? first_low : prev_end + 1;
        lag = det - first_low;
        for (int k = 0; k < nb; k++)
          for (int j = 0; j < p; j++) os[k * p + j] = bits[k];
        if (flips && lag == 0)
          for (int k = 0; k < nb; k++) begin
            b = k * p + half + int'($urandom_range(2));
            os[b] = !os[b];
          end
        for (int k = 0; k < nb; k++) begin
          b = k * p + half + lag;
          rec[k] = (os[b] & os[b + 1]) | (os[b] & os[b + 2]) | (os[b + 1] & os[b + 2]);
        end
        if (rec[0]) begin
          iv.lo = det; iv.hi = det + p;
          prev_end = det + p;
        end else begin
          for (int i = 0; i < DW; i++) rd[i] = rec[1 + i];
          pe = pen && (rec[1 + DW] != ((^rd) ^ ptype));
          se = !rec[nb - 1];
          e.t = det + total; e.d = rd; e.ok = !(pe || se); e.pe = pe; e.se = se;
          eq.push_back(e);
          iv.lo = det; iv.hi = det + total;
          prev_end = det + total;
        end
        bq.push_back(iv);
        prev_lag = lag;
        prescale = 6'(p);
        par_en = pen;
        par_type = ptype;
      end else if (idx == 2) begin
        prescale = 6'($urandom_range(63));
        par_en = 1'($urandom_range(1));
        par_type = 1'($urandom_range(1));
      end
      rx = os[idx];
      if (idx == abort_idx) begin
        mid_reset();
        break;
      end
    end
  endtask

  task automatic glitch(input int p);
    int fl, det;
    iv_t iv;
    @(negedge clk);
    fl = cyc + 1;
    det = (fl > prev_end) ? fl : prev_end + 1;
    iv.lo = det; iv.hi = det + p;
    bq.push_back(iv);
    prev_end = det + p;
    prev_lag = 0;
    prescale = 6'(p);
    par_en = 1'b0;
    par_type = 1'b0;
    rx = 1'b0;
    drive(1'b0);
    drive(1'b1);
  endtask

  initial begin
    int v0, p0, s0, p, g;
    bit pen, bp, bs;
    rst_n = 1'b0;
    rx = 1'b1;
    prescale = 6'd16;
    par_en = 1'b0;
    par_type = 1'b0;
    repeat (3) @(negedge clk);
    chk("init_data", data, 32'd0);
    chk("init_valid", data_valid, 32'd0);
    chk("init_busy", busy, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    chk_en = 1'b1;
    idle(5);

    // 0xA5, prescale 8, no parity.
    v0 = n_valid; p0 = n_perr; s0 = n_serr;
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, -1);
    idle(6);
    chk("a5_data", data, 32'hA5);
    chk("a5_valid_cnt", n_valid - v0, 32'd1);
    chk("a5_err_cnt", (n_perr - p0) + (n_serr - s0), 32'd0);
    chk("a5_busy", busy, 32'd0);

    // 0x3C, prescale 16, even parity: first with a good parity bit, then with a bad one.
    v0 = n_valid; p0 = n_perr;
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2, -1);
    idle(6);
    chk("3c_data", data, 32'h3C);
    chk("3c_valid_cnt", n_valid - v0, 32'd1);
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2, -1);
    idle(6);
    chk("3c_perr_cnt", n_perr - p0, 32'd1);
    chk("3c_bad_valid_cnt", n_valid - v0, 32'd1);
    chk("3c_hold", data, 32'h3C);

    // 0xFF, prescale 32, odd parity, stop bit low.
    v0 = n_valid; p0 = n_perr; s0 = n_serr;
    send_frame(8'hFF, 32, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2, -1);
    idle(6);
    chk("ff_serr_cnt", n_serr - s0, 32'd1);
    chk("ff_perr_cnt", n_perr - p0, 32'd0);
    chk("ff_valid_cnt", n_valid - v0, 32'd0);
    chk("ff_hold", data, 32'h3C);

    // Start-bit glitch, then two back-to-back frames.
    v0 = n_valid; p0 = n_perr; s0 = n_serr;
    glitch(16);
    idle(40);
    chk("glitch_pulses", (n_valid - v0) + (n_perr - p0) + (n_serr - s0), 32'd0);
    chk("glitch_busy", busy, 32'd0);
    send_frame(8'h12, 16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, -1);
    send_frame(8'h34, 16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1);
    idle(6);
    chk("b2b_valid_cnt", n_valid - v0, 32'd2);
    chk("b2b_data", data, 32'h34);

    // Reset in the middle of data bit 4, then a clean 0x5A.
    send_frame(8'hC3, 16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3, 16 * 5 + 8);
    idle(5);
    v0 = n_valid;
    send_frame(8'h5A, 16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, -1);
    idle(6);
    chk("5a_data", data, 32'h5A);
    chk("5a_valid_cnt", n_valid - v0, 32'd1);

    // 0x96 at prescale 8, with one flipped centre sample per bit.
    p0 = n_perr; s0 = n_serr;
    send_frame(8'h96, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3, -1);
    idle(6);
    chk("96_data", data, 32'h96);
    chk("96_err_cnt", (n_perr - p0) + (n_serr - s0), 32'd0);

    // Random frames.
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(2))
        0:       p = 8;
        1:       p = 16;
        default: p = 32;
      endcase
      pen = 1'($urandom_range(1));
      bp = pen && ($urandom_range(5) == 0);
      bs = ($urandom_range(5) == 0);
      g = int'($urandom_range(3));
      if (prev_lag != 0 && g == 0) g = 1;
      send_frame(8'($urandom_range(255)), p, pen, 1'($urandom_range(1)), bp, bs,
                 1'($urandom_range(1)), g, -1);
    end

    idle(80);
    chk("queue_drain", eq.size(), 32'd0);
    chk("final_busy", busy, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
